// File: rtl/dsp_accum_round_sat_fifo.sv
// Accumulator output stage: half-up rounding shift, signed saturation and
// a small first-word-fall-through FIFO with a valid/ready consumer interface.
// A word sampled at edge k is rounded at edge k, saturated at edge k+1 and
// written into the FIFO at edge k+2.
module dsp_accum_round_sat_fifo #(
  parameter int IN_W  = 38,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p_valid_i,
  input  logic [IN_W-1:0]          p_i,
  output logic [OUT_W-1:0]         dout_o,
  output logic                     dout_valid_o,
  input  logic                     dout_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     sat_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Half-LSB rounding constant; zero when no shift is applied.
  localparam logic [IN_W:0] RND = (SHIFT > 0) ?
                                  ((IN_W+1)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

  // Saturation limits expressed on the widened rounding width.
  localparam logic signed [IN_W:0]  MAXV    = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0]  MINV    = ~MAXV;
  localparam logic [OUT_W-1:0]      OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0]  sum;
  logic signed [IN_W:0]  s1R_d;
  logic signed [IN_W:0]  s1R_q;
  logic                  s1Valid_q;

  logic [OUT_W-1:0]      s2Out_d;
  logic                  s2Sat_d;
  logic [OUT_W-1:0]      s2Out_q;
  logic                  s2Valid_q;
  logic                  sat_q;

  logic [OUT_W-1:0]      mem_q [DEPTH];
  logic [AW-1:0]         wrPtr_q;
  logic [AW-1:0]         rdPtr_q;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_d;
  logic                  drop_q;
  logic                  drop_d;
  logic                  isFull;
  logic                  popEn;
  logic                  wrEn;

  // Sign-extend one bit before adding the rounding constant so the sum never wraps.
  assign sum   = $signed({p_i[IN_W-1], p_i}) + $signed(RND);
  assign s1R_d = sum >>> SHIFT;

  // Stage 1: capture the rounded, shifted accumulator value.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
      s1R_q     <= '0;
    end else begin
      s1Valid_q <= p_valid_i;
      if (p_valid_i) s1R_q <= s1R_d;
    end
  end

  // Clamp the rounded value into the signed output range.
  always_comb begin
    s2Out_d = s1R_q[OUT_W-1:0];
    s2Sat_d = 1'b0;
    if (s1R_q > MAXV) begin
      s2Out_d = OUT_MAX;
      s2Sat_d = 1'b1;
    end else if (s1R_q < MINV) begin
      s2Out_d = OUT_MIN;
      s2Sat_d = 1'b1;
    end
  end

  // Stage 2: register the saturated sample and keep the sticky saturation flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2Valid_q <= 1'b0;
      s2Out_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Out_q <= s2Out_d;
        if (s2Sat_d) sat_q <= 1'b1;
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push alongside it.
  always_comb begin
    isFull  = (level_q == LW'(DEPTH));
    popEn   = (level_q != '0) && dout_ready_i;
    wrEn    = s2Valid_q && (!isFull || popEn);
    drop_d  = s2Valid_q && isFull && !popEn;
    level_d = level_q + LW'(wrEn) - LW'(popEn);
  end

  // FIFO storage needs no reset; emptiness is tracked by the level counter.
  always_ff @(posedge clk) begin
    if (wrEn && !reset) mem_q[wrPtr_q] <= s2Out_q;
  end

  // FIFO pointers, occupancy and the one-cycle drop indicator.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (wrEn)  wrPtr_q <= wrPtr_q + AW'(1);
      if (popEn) rdPtr_q <= rdPtr_q + AW'(1);
      level_q <= level_d;
      drop_q  <= drop_d;
    end
  end

  assign dout_valid_o = (level_q != '0);
  assign dout_o       = dout_valid_o ? mem_q[rdPtr_q] : '0;
  assign level_o      = level_q;
  assign full_o       = isFull;
  assign sat_o        = sat_q;
  assign drop_o       = drop_q;

endmodule
